nim_trig_ctrl: RTL and testbench
================================

NIM_TRIG_CTRL -- requirements
Module: nim_trig_ctrl

Interface
REQ-001 Parameter N_CH, default 8: number of conditioned NIM channel inputs.
REQ-002 Parameter CNT_W, default 32: width of the status counters.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; 1 = arm the trigger, 0 = return to IDLE.
REQ-006 ch_trig  input  N_CH  per-channel conditioned trigger levels from the NIM input channels.
REQ-007 ch_mask  input  N_CH  1 = channel participates in coincidence.
REQ-008 min_mult  input  $clog2(N_CH+1)  minimum number of masked channels high; 0 disables triggering.
REQ-009 pulse_width  input  8  trig_out width in clk cycles; 0 is treated as 1.
REQ-010 deadtime  input  16  cycles spent in DEAD after each pulse.
REQ-011 prescale  input  16  accept 1 of every prescale events; 0 and 1 both mean every event (PRESCALE_EN only).
REQ-012 veto  input  1  level; an event seen while veto=1 is rejected.
REQ-013 reset_cnt  input  1  clears both counters.
REQ-014 trig_out  output  1  registered global trigger pulse.
REQ-015 busy  output  1  registered; high while in FIRE or DEAD.
REQ-016 accept_cnt  output  CNT_W  count of issued triggers.
REQ-017 reject_cnt  output  CNT_W  count of rejected events.

Function
REQ-018 ch_trig, veto and run shall be registered once (ch_r, veto_r, run_r) before use.
REQ-019 coinc = (popcount(ch_r & mask_s) >= mult_s) && (mult_s != 0); event = coinc && !coinc_d, where coinc_d is coinc delayed one cycle.
REQ-020 Config shadow registers (mask_s, mult_s, width_s, dead_s, pre_s) shall load from the inputs only on the IDLE->ARMED transition and hold constant otherwise.
REQ-021 The FSM shall have exactly four states: IDLE, ARMED, FIRE and DEAD.
REQ-022 IDLE->ARMED when run_r=1.
REQ-023 ARMED->IDLE when run_r=0.
REQ-024 ARMED->FIRE on an event with veto_r=0 that passes the prescaler.
REQ-025 In FIRE, trig_out shall be 1 for exactly max(width_s,1) cycles; the state then goes to DEAD, or directly to ARMED if dead_s=0.
REQ-026 DEAD lasts exactly dead_s cycles, then goes to ARMED, or to IDLE if run_r=0.
REQ-027 A run_r drop during FIRE or DEAD shall not truncate the pulse or the deadtime.
REQ-028 Latency: if the coincidence condition first appears at the inputs on edge k, trig_out shall rise after edge k+3.
REQ-029 accept_cnt shall increment on each entry into FIRE.
REQ-030 reject_cnt shall increment on an event in ARMED with veto_r=1, and on any event in FIRE or DEAD; events in IDLE are not counted.
REQ-031 Both counters shall saturate at all-ones.
REQ-032 reset_cnt has priority over an increment in the same cycle: the counter shall read 0 next cycle.

Reset
REQ-033 reset shall force state=IDLE, trig_out=0, busy=0, accept_cnt=0, reject_cnt=0, all pipeline and shadow registers=0, and the prescale counter=0.
REQ-034 reset asserted mid-pulse shall drop trig_out on the next edge.

Configuration
REQ-035 Macro NIM_TRIG_PRESCALE_EN compiles in the prescale port and a 16-bit prescale counter.
REQ-036 The prescale counter shall clear on IDLE->ARMED and advance modulo pre_s on each vetoless event in ARMED.
REQ-037 An event passes the prescaler only when the counter equals 0.
REQ-038 A prescaled-away event shall stay in ARMED and be counted in neither counter.
REQ-039 Without NIM_TRIG_PRESCALE_EN, the prescale port is absent and every vetoless event in ARMED passes.

Structure
REQ-040 Package nim_trig_pkg shall hold the state enum (IDLE, ARMED, FIRE, DEAD), the widths of pulse_width, deadtime and prescale, and the default N_CH and CNT_W.
REQ-041 Sub-module nim_trig_coinc shall implement input registering, masked popcount, the threshold compare and the event edge detect.

Verification
REQ-042 N_CH=8, mask=0x03, min_mult=2, run=1: ch_trig 0x01->0x03 held 10 cycles -> one trig_out pulse of pulse_width=4 cycles, 3 cycles after the input edge; accept_cnt=1.
REQ-043 deadtime=20: a second coincidence 10 cycles after the first pulse ends -> no pulse; reject_cnt=1; busy high for 4+20 cycles.
REQ-044 veto=1 during a coincidence -> no pulse; reject_cnt increments; accept_cnt unchanged.
REQ-045 NIM_TRIG_PRESCALE_EN, prescale=3: 9 separated events -> 3 pulses, on events 1, 4 and 7; reject_cnt=0.
REQ-046 run dropped during DEAD -> deadtime completes, then IDLE; inputs changed while ARMED are ignored until the next arm.
REQ-047 reset asserted mid-pulse, and reset_cnt asserted together with an accept -> trig_out=0 next cycle and counters read 0.

Source files
------------

// File: rtl/nim_trig_pkg.sv
// Shared types and widths for the NIM trigger controller.
package nim_trig_pkg;
  localparam int DEF_N_CH  = 8;
  localparam int DEF_CNT_W = 32;
  localparam int PW_W      = 8;
  localparam int DT_W      = 16;
  localparam int PS_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2,
    DEAD  = 2'd3
  } state_t;
endpackage

// File: rtl/nim_trig_coinc.sv
// Input registering, masked multiplicity compare and rising-edge event detect.
module nim_trig_coinc
  import nim_trig_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_run,
  input  logic                      i_veto,
  input  logic [N_CH-1:0]           i_ch_trig,
  input  logic [N_CH-1:0]           i_mask_s,
  input  logic [$clog2(N_CH+1)-1:0] i_mult_s,
  output logic                      o_run_r,
  output logic                      o_veto_r,
  output logic                      o_event
);
  localparam int MW = $clog2(N_CH+1);

  logic [N_CH-1:0] r_ch;
  logic            r_coinc;
  logic            r_coinc_d;
  logic [MW-1:0]   w_pop;
  logic            w_coinc;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_CH; i++) w_pop = w_pop + MW'(r_ch[i] & i_mask_s[i]);
  end

  assign w_coinc = (w_pop >= i_mult_s) && (i_mult_s != '0);

  // NOTE: every register here uses <= so the pipeline stages shift by exactly one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch      <= '0;
      o_run_r   <= 1'b0;
      o_veto_r  <= 1'b0;
      r_coinc   <= 1'b0;
      r_coinc_d <= 1'b0;
    end else begin
      r_ch      <= i_ch_trig;
      o_run_r   <= i_run;
      o_veto_r  <= i_veto;
      r_coinc   <= w_coinc;
      r_coinc_d <= r_coinc;
    end
  end

  assign o_event = r_coinc & ~r_coinc_d;
endmodule

// File: rtl/nim_trig_ctrl.sv
// NIM coincidence trigger controller; define NIM_TRIG_PRESCALE_EN for the event prescaler.
module nim_trig_ctrl
  import nim_trig_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [N_CH-1:0]           ch_trig,
  input  logic [N_CH-1:0]           ch_mask,
  input  logic [$clog2(N_CH+1)-1:0] min_mult,
  input  logic [PW_W-1:0]           pulse_width,
  input  logic [DT_W-1:0]           deadtime,
`ifdef NIM_TRIG_PRESCALE_EN
  input  logic [PS_W-1:0]           prescale,
`endif
  input  logic                      veto,
  input  logic                      reset_cnt,
  output logic                      trig_out,
  output logic                      busy,
  output logic [CNT_W-1:0]          accept_cnt,
  output logic [CNT_W-1:0]          reject_cnt
);
  localparam int MW = $clog2(N_CH+1);

  state_t          r_state, w_next;
  logic [N_CH-1:0] r_mask_s;
  logic [MW-1:0]   r_mult_s;
  logic [PW_W-1:0] r_width_s, w_width_m1;
  logic [DT_W-1:0] r_dead_s, r_cnt;
  logic            w_run_r, w_veto_r, w_event;
  logic            w_arm, w_accept, w_reject, w_pass;

  nim_trig_coinc #(.N_CH(N_CH)) u_coinc (
    .clk       (clk),
    .reset     (reset),
    .i_run     (run),
    .i_veto    (veto),
    .i_ch_trig (ch_trig),
    .i_mask_s  (r_mask_s),
    .i_mult_s  (r_mult_s),
    .o_run_r   (w_run_r),
    .o_veto_r  (w_veto_r),
    .o_event   (w_event)
  );

`ifdef NIM_TRIG_PRESCALE_EN
  logic [PS_W-1:0] r_pre_s, r_pcnt;
  logic            w_padv;
  assign w_pass = (r_pcnt == '0);
`else
  assign w_pass = 1'b1;
`endif

  assign w_width_m1 = (r_width_s == '0) ? '0 : r_width_s - PW_W'(1);

  // NOTE: all outputs of this block get a default first so no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_arm    = 1'b0;
    w_accept = 1'b0;
    w_reject = 1'b0;
`ifdef NIM_TRIG_PRESCALE_EN
    w_padv   = 1'b0;
`endif
    case (r_state)
      IDLE: if (w_run_r) begin
        w_next = ARMED;
        w_arm  = 1'b1;
      end
      ARMED: begin
        if (!w_run_r) w_next = IDLE;
        else if (w_event) begin
          if (w_veto_r) w_reject = 1'b1;
          else begin
`ifdef NIM_TRIG_PRESCALE_EN
            w_padv = 1'b1;
`endif
            if (w_pass) begin
              w_next   = FIRE;
              w_accept = 1'b1;
            end
          end
        end
      end
      FIRE: begin
        w_reject = w_event;
        if (r_cnt == '0) w_next = (r_dead_s == '0) ? ARMED : DEAD;
      end
      DEAD: begin
        w_reject = w_event;
        if (r_cnt == '0) w_next = w_run_r ? ARMED : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mask_s  <= '0;
      r_mult_s  <= '0;
      r_width_s <= '0;
      r_dead_s  <= '0;
      r_cnt     <= '0;
      trig_out  <= 1'b0;
      busy      <= 1'b0;
`ifdef NIM_TRIG_PRESCALE_EN
      r_pre_s   <= '0;
      r_pcnt    <= '0;
`endif
    end else begin
      r_state  <= w_next;
      trig_out <= (r_state == FIRE);
      busy     <= (r_state == FIRE) || (r_state == DEAD);
      if (w_arm) begin
        r_mask_s  <= ch_mask;
        r_mult_s  <= min_mult;
        r_width_s <= pulse_width;
        r_dead_s  <= deadtime;
      end
      // r_cnt holds the remaining cycles minus one of the current FIRE or DEAD phase.
      if (w_accept) r_cnt <= {{(DT_W-PW_W){1'b0}}, w_width_m1};
      else if (r_state == FIRE && w_next == DEAD) r_cnt <= r_dead_s - DT_W'(1);
      else if (r_cnt != '0) r_cnt <= r_cnt - DT_W'(1);
`ifdef NIM_TRIG_PRESCALE_EN
      if (w_arm) begin
        r_pre_s <= prescale;
        r_pcnt  <= '0;
      end else if (w_padv) begin
        r_pcnt <= (r_pcnt + PS_W'(1) >= r_pre_s) ? '0 : r_pcnt + PS_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset || reset_cnt) begin
      accept_cnt <= '0;
      reject_cnt <= '0;
    end else begin
      if (w_accept && accept_cnt != '1) accept_cnt <= accept_cnt + CNT_W'(1);
      if (w_reject && reject_cnt != '1) reject_cnt <= reject_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_nim_trig_ctrl.sv
// Self-checking bench for nim_trig_ctrl: cycle model plus directed and random stimulus.
module tb_nim_trig_ctrl;
  localparam int N_CH  = 8;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, run, veto, reset_cnt;
  logic [N_CH-1:0]  ch_trig, ch_mask;
  logic [3:0]       min_mult;
  logic [7:0]       pulse_width;
  logic [15:0]      deadtime;
`ifdef NIM_TRIG_PRESCALE_EN
  logic [15:0]      prescale;
`endif
  logic             trig_out, busy;
  logic [CNT_W-1:0] accept_cnt, reject_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit cmp_en  = 1'b0;

  nim_trig_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .ch_trig     (ch_trig),
    .ch_mask     (ch_mask),
    .min_mult    (min_mult),
    .pulse_width (pulse_width),
    .deadtime    (deadtime),
`ifdef NIM_TRIG_PRESCALE_EN
    .prescale    (prescale),
`endif
    .veto        (veto),
    .reset_cnt   (reset_cnt),
    .trig_out    (trig_out),
    .busy        (busy),
    .accept_cnt  (accept_cnt),
    .reject_cnt  (reject_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: inputs seen one edge ago, coincidence one and two edges ago,
  // an "armed" flag and remaining FIRE / DEAD cycle counts.
  logic [N_CH-1:0] p_ch, s_mask;
  bit  p_c1, p_c2, p_veto, p_run, m_armed;
  int  s_mult, s_width, s_dead, s_pre, pcnt, m_fire, m_dead;
  bit  e_trig, e_busy, ev, c_new, acc_i, rej_i;
  int  e_acc, e_rej;

  always @(posedge clk) begin
    if (reset) begin
      p_ch = '0; s_mask = '0; p_c1 = 0; p_c2 = 0; p_veto = 0; p_run = 0; m_armed = 0;
      s_mult = 0; s_width = 0; s_dead = 0; s_pre = 0; pcnt = 0; m_fire = 0; m_dead = 0;
      e_trig = 0; e_busy = 0; e_acc = 0; e_rej = 0;
    end else begin
      c_new  = ($countones(p_ch & s_mask) >= s_mult) && (s_mult != 0);
      ev     = p_c1 && !p_c2;
      acc_i  = 0;
      rej_i  = 0;
      e_trig = (m_fire > 0);
      e_busy = (m_fire > 0) || (m_dead > 0);
      if (m_fire > 0) begin
        rej_i = ev;
        m_fire--;
        if (m_fire == 0) m_dead = s_dead;
      end else if (m_dead > 0) begin
        rej_i = ev;
        m_dead--;
        if (m_dead == 0 && !p_run) m_armed = 0;
      end else if (m_armed) begin
        if (!p_run) m_armed = 0;
        else if (ev) begin
          if (p_veto) rej_i = 1;
          else begin
            if (pcnt == 0) begin
              acc_i  = 1;
              m_fire = (s_width == 0) ? 1 : s_width;
            end
            pcnt = (s_pre <= 1) ? 0 : (pcnt + 1) % s_pre;
          end
        end
      end else if (p_run) begin
        m_armed = 1;
        s_mask  = ch_mask;
        s_mult  = int'(min_mult);
        s_width = int'(pulse_width);
        s_dead  = int'(deadtime);
`ifdef NIM_TRIG_PRESCALE_EN
        s_pre   = int'(prescale);
`else
        s_pre   = 1;
`endif
        pcnt    = 0;
      end
      if (reset_cnt) begin
        e_acc = 0;
        e_rej = 0;
      end else begin
        if (acc_i && e_acc < MAXC) e_acc++;
        if (rej_i && e_rej < MAXC) e_rej++;
      end
      p_c2 = p_c1; p_c1 = c_new; p_ch = ch_trig; p_veto = veto; p_run = run;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("trig_out", {31'd0, trig_out}, {31'd0, e_trig});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("accept_cnt", 32'(accept_cnt), e_acc);
      check("reject_cnt", 32'(reject_cnt), e_rej);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rearm();
    run = 1'b0; tick(4);
    run = 1'b1; tick(4);
  endtask

  int first, nt, nb, e, seen, hits;

  initial begin
    reset = 1; run = 0; veto = 0; reset_cnt = 0; ch_trig = '0; ch_mask = '0;
    min_mult = '0; pulse_width = '0; deadtime = '0;
`ifdef NIM_TRIG_PRESCALE_EN
    prescale = '0;
`endif
    tick(3);
    cmp_en = 1'b1;
    check("rst_trig", {31'd0, trig_out}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_acc", 32'(accept_cnt), 0);
    check("rst_rej", 32'(reject_cnt), 0);
    reset = 0;

    // Basic pulse, latency, width and deadtime with a rejected event inside DEAD.
    ch_mask = 8'h03; min_mult = 4'd2; pulse_width = 8'd4; deadtime = 16'd20; run = 1;
    tick(5);
    ch_trig = 8'h01; tick(3);
    ch_trig = 8'h03; e = cyc; first = -1; nt = 0; nb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (trig_out) begin
        nt++;
        if (first < 0) first = cyc - (e + 1);
      end
      if (busy) nb++;
      if (i == 10) ch_trig = 8'h01;
      if (i == 18) ch_trig = 8'h03;
      if (i == 22) ch_trig = 8'h00;
    end
    check("latency", first, 3);
    check("pulse_len", nt, 4);
    check("busy_len", nb, 24);
    check("acc_first", 32'(accept_cnt), 1);
    check("rej_dead", 32'(reject_cnt), 1);

    // Vetoed coincidence.
    veto = 1; ch_trig = 8'h03; nt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (trig_out) nt++;
    end
    ch_trig = 8'h00; tick(2); veto = 0; tick(2);
    check("veto_pulse", nt, 0);
    check("veto_acc", 32'(accept_cnt), 1);
    check("veto_rej", 32'(reject_cnt), 2);

    // run dropped during DEAD: deadtime completes, then IDLE ignores events.
    ch_trig = 8'h03; nb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (i == 6) ch_trig = 8'h00;
      if (i == 10) run = 0;
    end
    check("rundrop_busy", nb, 24);
    ch_trig = 8'h03; tick(6); ch_trig = 8'h00; tick(4);
    check("idle_acc", 32'(accept_cnt), 2);
    check("idle_rej", 32'(reject_cnt), 2);

    // Config changed while ARMED is ignored until the next arm.
    run = 1; tick(4);
    ch_mask = 8'h0C; ch_trig = 8'h0C; tick(8); ch_trig = 8'h00; tick(4);
    check("mask_hold", 32'(accept_cnt), 2);
    ch_trig = 8'h03; tick(30); ch_trig = 8'h00; tick(2);
    check("old_mask_acc", 32'(accept_cnt), 3);
    rearm();
    ch_trig = 8'h0C; tick(30); ch_trig = 8'h00; tick(2);
    check("new_mask_acc", 32'(accept_cnt), 4);

    // Reset in the middle of a pulse.
    ch_mask = 8'h03; rearm();
    ch_trig = 8'h03; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      seen = int'(trig_out);
    end
    check("pulse_seen", seen, 1);
    reset = 1; ch_trig = 8'h00; @(negedge clk);
    check("midrst_trig", {31'd0, trig_out}, 0);
    check("midrst_acc", 32'(accept_cnt), 0);
    check("midrst_rej", 32'(reject_cnt), 0);
    reset = 0; tick(6);

    // reset_cnt coinciding with entry into FIRE.
    ch_trig = 8'h03; tick(30); ch_trig = 8'h00; tick(2);
    check("pre_rstcnt_acc", 32'(accept_cnt), 1);
    ch_trig = 8'h03; tick(2);
    reset_cnt = 1; tick(1); reset_cnt = 0;
    check("rstcnt_acc", 32'(accept_cnt), 0);
    tick(1);
    check("rstcnt_trig", {31'd0, trig_out}, 1);
    tick(30); ch_trig = 8'h00; tick(2);

    // Saturation of the accept counter.
    pulse_width = 8'd1; deadtime = 16'd0; rearm();
    for (int n = 0; n < 20; n++) begin
      ch_trig = 8'h03; tick(2); ch_trig = 8'h00; tick(2);
    end
    tick(4);
    check("acc_sat", 32'(accept_cnt), MAXC);

`ifdef NIM_TRIG_PRESCALE_EN
    // Prescale of 3: events 1, 4 and 7 of 9 produce pulses.
    prescale = 16'd3; pulse_width = 8'd2; deadtime = 16'd3; rearm();
    reset_cnt = 1; tick(1); reset_cnt = 0;
    nt = 0; hits = 0;
    for (int n = 0; n < 9; n++) begin
      ch_trig = 8'h03;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (i == 3) ch_trig = 8'h00;
        if (trig_out) begin
          nt++;
          hits = hits | (1 << n);
        end
      end
    end
    check("pre_cycles", nt, 6);
    check("pre_events", hits, 32'b001001001);
    check("pre_acc", 32'(accept_cnt), 3);
    check("pre_rej", 32'(reject_cnt), 0);
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) ch_trig = 8'($urandom);
      if ($urandom_range(15) == 0) veto = ~veto;
      if ($urandom_range(40) == 0) run = ~run;
      if ($urandom_range(30) == 0) begin
        ch_mask     = 8'($urandom);
        min_mult    = 4'($urandom_range(4));
        pulse_width = 8'($urandom_range(5));
        deadtime    = 16'($urandom_range(6));
`ifdef NIM_TRIG_PRESCALE_EN
        prescale    = 16'($urandom_range(4));
`endif
      end
      reset_cnt = ($urandom_range(99) == 0);
      reset     = ($urandom_range(499) == 0);
    end
    reset = 0; reset_cnt = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
